bcd_convert_scheduler: RTL and testbench

Shares one external binary-to-BCD converter (shift-and-add-3 engine) among NUM_REQ requesters, e.g. the occurrence counters that feed the 7-segment digit drivers.
- Arbitrates round-robin.
- Launches one conversion at a time through a start/done handshake.
- Captures the BCD result and returns it to the granted requester with a one-cycle acknowledge.
- Sits between the counter logic and the shared converter; holds no display state of its own.

---
 rtl/bcd_convert_scheduler.sv | 132 +++++++++++++
 tb/tb_bcd_convert_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter among NUM_REQ requesters.
// Optional converter watchdog enabled by defining BCD_SCHED_TIMEOUT_EN.
module bcd_convert_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int BCD_W       = 12,
   parameter int TIMEOUT_CYC = 32
) (
   input  logic                        iClk,
   input  logic                        iRst_n,
   input  logic [NUM_REQ-1:0]          iReq,
   input  logic [NUM_REQ*DATA_W-1:0]   iData,
   output logic [NUM_REQ-1:0]          oAck,
   output logic [BCD_W-1:0]            oResult,
   output logic                        oBusy,
   output logic                        oConvStart,
   output logic [DATA_W-1:0]           oConvData,
   input  logic                        iConvDone,
   input  logic [BCD_W-1:0]            iConvBcd,
   output logic                        oErr
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] ptr, idx, grant_idx, idx_inc;
   logic [IDX_W:0]   cand;
   logic             grant_vld;
   logic             timeout;

   // Scan offsets from highest to lowest so the nearest set bit at/after ptr wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
         if (iReq[cand[IDX_W-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

   assign idx_inc = (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;

`ifdef BCD_SCHED_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC+1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err;

   // A done arriving on the limit cycle wins over the timeout.
   assign timeout = (state == WAIT) && !iConvDone &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYC-1));

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state == START)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
         if (timeout)            err      <= 1'b1;
      end
   end

   assign oErr = err;
`else
   assign timeout = 1'b0;
   assign oErr    = 1'b0;
`endif

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      oConvStart = 1'b0;
      oAck       = '0;
      oBusy      = 1'b1;
      case (state)
         IDLE: begin
            oBusy = 1'b0;
            if (grant_vld) state_nxt = START;
         end
         START: begin
            oConvStart = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            if (iConvDone || timeout) state_nxt = RESP;
         end
         RESP: begin
            oAck[idx] = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand and index are frozen at grant; requester changes after that are ignored.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         idx       <= '0;
         ptr       <= '0;
         oConvData <= '0;
         oResult   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  idx       <= grant_idx;
                  oConvData <= iData[int'(grant_idx)*DATA_W +: DATA_W];
               end
            end
            WAIT: begin
               if (iConvDone)    oResult <= iConvBcd;
               else if (timeout) oResult <= '1;
            end
            RESP:    ptr <= idx_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Directed bench for bcd_convert_scheduler with a queue-based reference model and converter model.
module tb_bcd_convert_scheduler;
   localparam int N = 4;

   logic          iClk = 1'b0;
   logic          iRst_n = 1'b1;
   logic [N-1:0]  iReq = '0;
   logic [N*8-1:0] iData = '0;
   logic [N-1:0]  oAck;
   logic [11:0]   oResult;
   logic          oBusy, oConvStart, oErr;
   logic [7:0]    oConvData;
   logic          iConvDone = 1'b0;
   logic [11:0]   iConvBcd = '0;

   bcd_convert_scheduler #(.NUM_REQ(N), .DATA_W(8), .BCD_W(12), .TIMEOUT_CYC(32)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iData(iData), .oAck(oAck),
      .oResult(oResult), .oBusy(oBusy), .oConvStart(oConvStart), .oConvData(oConvData),
      .iConvDone(iConvDone), .iConvBcd(iConvBcd), .oErr(oErr));

   always #5 iClk = ~iClk;

   typedef struct { int idx; logic [7:0] op; logic [11:0] res; bit to; } job_t;
   typedef struct { logic [3:0] ack; logic [11:0] res; } obs_t;

   int    compared = 0, mismatched = 0;
   job_t  q[$];
   obs_t  ack_log[$];
   int    ptr_m = 0, cyc = 0, start_cnt = 0, start_cyc = 0, ack_cyc = 0;
   logic  err_exp = 1'b0;
   logic [11:0] res_exp = '0;
   logic [N-1:0] last_req = '0;
   logic [N*8-1:0] last_data = '0;

   int    conv_lat = 1, conv_cnt = 0;
   bit    conv_mute = 0, force_done = 0;
   logic [7:0] conv_op = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [11:0] bcd(input logic [7:0] v);
      int h, t, u;
      h = v / 100; t = (v / 10) % 10; u = v % 10;
      return {h[3:0], t[3:0], u[3:0]};
   endfunction

   function automatic int rr_pick(input logic [N-1:0] req, input int p);
      for (int k = 0; k < N; k++) if (req[(p+k)%N]) return (p+k)%N;
      return -1;
   endfunction

   // Reference model and per-cycle compare
   initial forever begin
      @(negedge iClk);
      if (!iRst_n) begin
         chk("rst_ack", oAck, 0);
         chk("rst_busy", oBusy, 0);
         chk("rst_start", oConvStart, 0);
         chk("rst_convdata", oConvData, 0);
         chk("rst_result", oResult, 0);
         chk("rst_err", oErr, 0);
         q.delete();
         ptr_m = 0; err_exp = 1'b0; res_exp = '0;
      end else begin
         if (oConvStart) begin
            job_t j;
            int g;
            chk("start_while_busy", q.size(), 0);
            g = rr_pick(last_req, ptr_m);
            if (g < 0) begin chk("grant_without_req", 0, 1); g = 0; end
            j.idx = g;
            j.op  = last_data[g*8 +: 8];
            j.to  = conv_mute;
            j.res = conv_mute ? 12'hFFF : bcd(j.op);
            q.push_back(j);
            start_cnt++; start_cyc = cyc;
         end
         chk("busy", oBusy, q.size() != 0);
         if (q.size() != 0) chk("conv_data", oConvData, q[0].op);
         if (oAck != 0) begin
            obs_t o;
            chk("ack_onehot", $onehot(oAck), 1);
            if (q.size() == 0) chk("ack_without_job", oAck, 0);
            else begin
               job_t j;
               j = q.pop_front();
               chk("ack_idx", oAck, 1 << j.idx);
               chk("ack_result", oResult, j.res);
               if (j.to) err_exp = 1'b1;
               res_exp = j.res;
               ptr_m = (j.idx + 1) % N;
            end
            o.ack = oAck; o.res = oResult;
            ack_log.push_back(o);
            ack_cyc = cyc;
         end else begin
            chk("result_hold", oResult, res_exp);
         end
         chk("err", oErr, err_exp);
      end
      last_req = iReq; last_data = iData;
      cyc++;
   end

   // Converter model: answers conv_lat cycles after the start pulse
   initial forever begin
      @(posedge iClk); #2;
      iConvDone = 1'b0;
      if (force_done) begin
         iConvDone = 1'b1; iConvBcd = 12'h999; force_done = 0;
      end else if (conv_cnt > 0) begin
         conv_cnt--;
         if (conv_cnt == 0) begin iConvDone = 1'b1; iConvBcd = bcd(conv_op); end
      end
      if (oConvStart && !conv_mute && iRst_n) begin
         conv_cnt = conv_lat; conv_op = oConvData;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge iClk); #1; end
   endtask

   task automatic do_reset();
      iRst_n = 1'b0; conv_cnt = 0; force_done = 0;
      tick(2);
      iRst_n = 1'b1;
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      iData[i*8 +: 8] = v;
   endtask

   task automatic wait_acks(input int n, input int budget);
      int k = 0;
      while (ack_log.size() < n && k < budget) begin tick(1); k++; end
      chk("wait_acks_timeout", ack_log.size() >= n, 1);
   endtask

   task automatic wait_start(input int budget);
      int k = 0;
      while (!oConvStart && k < budget) begin tick(1); k++; end
      chk("wait_start_timeout", oConvStart, 1);
   endtask

   int base, sc;

   initial begin
      #1 iRst_n = 1'b0;
      tick(2);
      iRst_n = 1'b1;
      tick(1);

      // 1: single request, slow converter
      conv_lat = 9; base = ack_log.size(); sc = start_cnt;
      set_data(0, 8'd255); iReq = 4'b0001;
      wait_acks(base + 1, 40);
      iReq = '0;
      chk("t1_busy_fall", oBusy, 0);
      tick(4);
      chk("t1_start_once", start_cnt - sc, 1);
      chk("t1_ack", ack_log[base].ack, 4'b0001);
      chk("t1_result", ack_log[base].res, 12'h255);
      chk("t1_latency", ack_cyc - start_cyc, 10);

      // 2: all requesters held, rotation 0,1,2,3,0
      do_reset();
      conv_lat = 1; base = ack_log.size();
      set_data(0, 8'd7); set_data(1, 8'd42); set_data(2, 8'd100); set_data(3, 8'd199);
      iReq = 4'b1111;
      wait_acks(base + 5, 60);
      iReq = '0;
      tick(3);
      chk("t2_ack0", ack_log[base].ack, 4'b0001);   chk("t2_res0", ack_log[base].res, 12'h007);
      chk("t2_ack1", ack_log[base+1].ack, 4'b0010); chk("t2_res1", ack_log[base+1].res, 12'h042);
      chk("t2_ack2", ack_log[base+2].ack, 4'b0100); chk("t2_res2", ack_log[base+2].res, 12'h100);
      chk("t2_ack3", ack_log[base+3].ack, 4'b1000); chk("t2_res3", ack_log[base+3].res, 12'h199);
      chk("t2_ack4", ack_log[base+4].ack, 4'b0001);
      chk("t2_min_latency", ack_cyc - start_cyc, 2);

      // 3: pointer wrap after idx 2
      do_reset();
      conv_lat = 3; base = ack_log.size();
      set_data(2, 8'd5); set_data(3, 8'd3); set_data(0, 8'd9);
      iReq = 4'b0100;
      wait_acks(base + 1, 30);
      iReq = 4'b1001;
      wait_acks(base + 3, 40);
      iReq = '0;
      tick(3);
      chk("t3_ack_a", ack_log[base+1].ack, 4'b1000); chk("t3_res_a", ack_log[base+1].res, 12'h003);
      chk("t3_ack_b", ack_log[base+2].ack, 4'b0001); chk("t3_res_b", ack_log[base+2].res, 12'h009);

      // 4: request dropped and operand changed mid-job
      do_reset();
      conv_lat = 6; base = ack_log.size();
      set_data(1, 8'd64); iReq = 4'b0010;
      wait_start(10);
      tick(1);
      iReq = '0; set_data(1, 8'h99);
      tick(1);
      chk("t4_convdata_held", oConvData, 8'h40);
      wait_acks(base + 1, 30);
      tick(3);
      chk("t4_ack", ack_log[base].ack, 4'b0010);
      chk("t4_result", ack_log[base].res, 12'h064);

      // 5: reset during WAIT, then a stale done; regrant from pointer 0
      do_reset();
      conv_lat = 2; base = ack_log.size();
      set_data(1, 8'd1); iReq = 4'b0010;
      wait_acks(base + 1, 20);
      iReq = '0;
      tick(2);
      conv_lat = 9;
      set_data(0, 8'd12); set_data(3, 8'd250); iReq = 4'b1001;
      wait_start(10);
      tick(3);
      iRst_n = 1'b0; conv_cnt = 0;
      base = ack_log.size();
      tick(1);
      chk("t5_rst_busy", oBusy, 0);
      chk("t5_rst_result", oResult, 0);
      iRst_n = 1'b1; force_done = 1;
      wait_acks(base + 2, 60);
      iReq = '0;
      tick(3);
      chk("t5_first_ack", ack_log[base].ack, 4'b0001);
      chk("t5_first_res", ack_log[base].res, 12'h012);
      chk("t5_second_ack", ack_log[base+1].ack, 4'b1000);
      chk("t5_second_res", ack_log[base+1].res, 12'h250);

`ifdef BCD_SCHED_TIMEOUT_EN
      // 6: converter silent -> watchdog answers with all-ones and sticky error
      do_reset();
      conv_mute = 1; base = ack_log.size();
      set_data(0, 8'd12); iReq = 4'b0001;
      wait_acks(base + 1, 60);
      iReq = '0;
      conv_mute = 0;
      chk("t6_err", oErr, 1);
      chk("t6_result", ack_log[base].res, 12'hFFF);
      chk("t6_wait_cycles", ack_cyc - start_cyc, 33);
      tick(2);
      conv_lat = 2; set_data(1, 8'd77); iReq = 4'b0010;
      wait_acks(base + 2, 30);
      iReq = '0;
      tick(2);
      chk("t6_result_ok", ack_log[base+1].res, 12'h077);
      chk("t6_err_sticky", oErr, 1);
`else
      chk("t6_err_tied", oErr, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "time limit");
   end
endmodule
